// File: rtl/fifo_prefetch_buf.sv
// Two-entry register buffer holding prefetched RAM read data.
// Gives the read side first-word-fall-through output with no combinational path from
// RAM data to m_valid/m_data.
// Capture (push) and pop may happen in the same cycle.
module fifo_prefetch_buf #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            buf_cnt,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data
);

   logic [DATA_WIDTH-1:0] data_q [2];
   logic                  head;
   logic                  tail;

   // Occupancy, head/tail rotation and data capture; the issue logic upstream
   // guarantees a capture never lands on a full buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_cnt   <= 2'd0;
         head      <= 1'b0;
         tail      <= 1'b0;
         data_q[0] <= '0;
         data_q[1] <= '0;
      end else begin
         if (push) begin
            data_q[tail] <= push_data;
            tail         <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         buf_cnt <= buf_cnt + 2'(push) - 2'(pop);
      end
   end

   assign m_valid = (buf_cnt != 2'd0);
   assign m_data  = data_q[head];

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller sequencing an external simple dual-port RAM
// (1-cycle registered read gated by rd_en).
// Writes go straight to RAM. Reads are prefetched into a 2-entry buffer so the output
// is first-word-fall-through at one word per cycle.
module fifo_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH+1:0] count,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic                  ram_rd_en,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CAP   = DEPTH + 2;
   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             rd_pend;
   logic [PTR_W-1:0] ram_used;
   logic             ram_full;
   logic             ram_empty;
   logic             pop;
   logic [1:0]       buf_cnt;
   logic [2:0]       occ_after_pop;

   // Full/empty come from registered pointers only, so a same-cycle write and
   // read issue can never hit the same RAM address.
   assign ram_used  = wr_ptr - rd_ptr;
   assign ram_full  = (ram_used == {1'b1, {ADDR_WIDTH{1'b0}}});
   assign ram_empty = (wr_ptr == rd_ptr);

   assign s_ready     = !ram_full;
   assign ram_wr_en   = s_valid && s_ready && !rst;
   assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_wr_data = s_data;

   // A read is issued only if the buffer will have room for it when it
   // returns, counting the read already in flight and this cycle's pop.
   assign pop           = m_valid && m_ready;
   assign occ_after_pop = 3'(buf_cnt) + 3'(rd_pend) - 3'(pop);
   assign ram_rd_en     = !rst && !ram_empty && (occ_after_pop < 3'd2);
   assign ram_rd_addr   = rd_ptr[ADDR_WIDTH-1:0];

   assign count = (ADDR_WIDTH+2)'(ram_used) + (ADDR_WIDTH+2)'(rd_pend)
                + (ADDR_WIDTH+2)'(buf_cnt);

   // Pointer and in-flight read tracking; a read in flight at reset is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_pend <= 1'b0;
      end else begin
         if (ram_wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (ram_rd_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         rd_pend <= ram_rd_en;
      end
   end

   // Occupancy can never exceed RAM depth plus the two buffer slots.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (int'(count) <= CAP);
      end
   end

   fifo_prefetch_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pend),
      .push_data (ram_rd_data),
      .pop       (pop),
      .buf_cnt   (buf_cnt),
      .m_valid   (m_valid),
      .m_data    (m_data)
   );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4, capacity 6).
// The bench models the dual-port RAM.
module tb_fifo_ctrl;

   logic       clk;
   logic       rst;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [3:0] count;
   logic [1:0] ram_wr_addr;
   logic [7:0] ram_wr_data;
   logic       ram_wr_en;
   logic [1:0] ram_rd_addr;
   logic       ram_rd_en;
   logic [7:0] ram_rd_data;

   int vectors;
   int miscompares;

   logic [7:0] mem [4];

   fifo_ctrl #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .count       (count),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_wr_en   (ram_wr_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_data (ram_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial ram_rd_data = 8'h00;
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b1; s_data = 8'hFF; m_ready = 1'b1;
      #1;
      vectors++; if (ram_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %0b expected 0", ram_wr_en); end
      vectors++; if (ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en: got %0b expected 0", ram_rd_en); end
      step(); step();
      rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      #1;
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid: got %0b expected 0", m_valid); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", count); end
      vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_s_ready: got %0b expected 1", s_ready); end
      vectors++; if (m_data !== 8'h00) begin miscompares++; $display("FAIL rst_m_data: got %0h expected 0", m_data); end
   endtask

   task automatic test_single_push();
      // cycle 0: push
      s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
      #1;
      vectors++; if (ram_wr_en !== 1'b1) begin miscompares++; $display("FAIL single_wr_en: got %0b expected 1", ram_wr_en); end
      vectors++; if (ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL single_rd_en_c0: got %0b expected 0", ram_rd_en); end
      step();
      // cycle 1: read issue
      s_valid = 1'b0;
      #1;
      vectors++; if (ram_rd_en !== 1'b1) begin miscompares++; $display("FAIL single_rd_en_c1: got %0b expected 1", ram_rd_en); end
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_m_valid_c1: got %0b expected 0", m_valid); end
      step();
      // cycle 2: capture
      #1;
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_m_valid_c2: got %0b expected 0", m_valid); end
      vectors++; if (ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL single_rd_en_c2: got %0b expected 0", ram_rd_en); end
      step();
      // cycle 3: head visible
      #1;
      vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_m_valid_c3: got %0b expected 1", m_valid); end
      vectors++; if (m_data !== 8'hA5) begin miscompares++; $display("FAIL single_m_data: got %0h expected a5", m_data); end
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", count); end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      #1;
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_m_valid: got %0b expected 0", m_valid); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL single_pop_count: got %0d expected 0", count); end
   endtask

   task automatic test_fill_stall();
      logic [7:0] next_v;
      int acc;
      int stall_cyc;
      int got;
      logic [7:0] exp_v;
      next_v = 8'h01; acc = 0; stall_cyc = -1;
      m_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         s_valid = 1'b1; s_data = next_v;
         #1;
         if (s_ready) begin
            acc++;
            next_v = next_v + 8'h01;
         end else if (stall_cyc < 0) begin
            stall_cyc = c;
         end
         step();
      end
      #1;
      vectors++; if (acc != 6) begin miscompares++; $display("FAIL fill_accepted: got %0d expected 6", acc); end
      vectors++; if (stall_cyc != 6) begin miscompares++; $display("FAIL fill_stall_cycle: got %0d expected 6", stall_cyc); end
      vectors++; if (count !== 4'd6) begin miscompares++; $display("FAIL fill_count: got %0d expected 6", count); end
      vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL fill_s_ready: got %0b expected 0", s_ready); end
      vectors++; if (ram_wr_en !== 1'b0) begin miscompares++; $display("FAIL fill_wr_en: got %0b expected 0", ram_wr_en); end
      vectors++; if (m_data !== 8'h01) begin miscompares++; $display("FAIL fill_head: got %0h expected 1", m_data); end
      // one pop frees a buffer slot; the refill read issues the same cycle
      m_ready = 1'b1;
      #1;
      vectors++; if (ram_rd_en !== 1'b1) begin miscompares++; $display("FAIL fill_pop_rd_en: got %0b expected 1", ram_rd_en); end
      vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL fill_pop_s_ready: got %0b expected 0", s_ready); end
      step();
      m_ready = 1'b0;
      #1;
      vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL fill_reassert: got %0b expected 1", s_ready); end
      vectors++; if (ram_wr_en !== 1'b1) begin miscompares++; $display("FAIL fill_late_wr_en: got %0b expected 1", ram_wr_en); end
      vectors++; if (ram_wr_data !== 8'h07) begin miscompares++; $display("FAIL fill_late_data: got %0h expected 7", ram_wr_data); end
      step();
      s_valid = 1'b0;
      got = 0; exp_v = 8'h02;
      for (int c = 0; c < 40 && got < 6; c++) begin
         m_ready = 1'b1;
         #1;
         if (m_valid) begin
            vectors++; if (m_data !== exp_v) begin miscompares++; $display("FAIL fill_drain: got %0h expected %0h", m_data, exp_v); end
            exp_v = exp_v + 8'h01;
            got++;
         end
         step();
      end
      m_ready = 1'b0;
      #1;
      vectors++; if (got != 6) begin miscompares++; $display("FAIL fill_drain_timeout: got %0d words expected 6", got); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL fill_drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_back_to_back();
      int in_v;
      int out_v;
      int first_pop;
      int last_pop;
      in_v = 0; out_v = 0; first_pop = -1; last_pop = -1;
      for (int cyc = 0; cyc < 200 && out_v < 64; cyc++) begin
         s_valid = (in_v < 64);
         s_data  = 8'(in_v);
         m_ready = 1'b1;
         #1;
         if (s_valid) begin
            vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_s_ready: got %0b expected 1 at cycle %0d", s_ready, cyc); end
         end
         if (m_valid) begin
            vectors++; if (m_data !== 8'(out_v)) begin miscompares++; $display("FAIL b2b_data: got %0h expected %0h", m_data, out_v); end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            out_v++;
         end
         if (s_valid && s_ready) in_v++;
         step();
      end
      s_valid = 1'b0; m_ready = 1'b0;
      vectors++; if (out_v != 64) begin miscompares++; $display("FAIL b2b_words: got %0d expected 64", out_v); end
      vectors++; if (first_pop != 3) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 3", first_pop); end
      vectors++; if (last_pop != 66) begin miscompares++; $display("FAIL b2b_last_cycle: got %0d expected 66", last_pop); end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      int occ;
      int pushed;
      int popped;
      occ = 0; pushed = 0; popped = 0;
      for (int cyc = 0; cyc < 20000 && popped < 1000; cyc++) begin
         s_valid = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         s_data  = 8'($urandom);
         m_ready = 1'($urandom_range(0, 1));
         #1;
         vectors++; if (int'(count) != occ) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", count, occ); end
         vectors++; if (count > 4'd6) begin miscompares++; $display("FAIL rand_cap: got %0d expected <=6", count); end
         if (m_valid && m_ready) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++; $display("FAIL rand_underflow: got %0h expected no data", m_data);
            end else begin
               if (m_data !== q[0]) begin miscompares++; $display("FAIL rand_data: got %0h expected %0h", m_data, q[0]); end
               void'(q.pop_front());
            end
            popped++; occ--;
         end
         if (s_valid && s_ready) begin
            q.push_back(s_data);
            pushed++; occ++;
         end
         step();
      end
      s_valid = 1'b0; m_ready = 1'b0;
      vectors++; if (popped != 1000) begin miscompares++; $display("FAIL rand_timeout: got %0d words expected 1000", popped); end
   endtask

   task automatic test_reset_mid();
      int acc;
      acc = 0;
      m_ready = 1'b0;
      for (int c = 0; c < 20 && acc < 6; c++) begin
         s_valid = 1'b1; s_data = 8'(8'h10 + acc);
         #1;
         if (s_ready) acc++;
         step();
      end
      s_valid = 1'b0;
      #1;
      vectors++; if (count !== 4'd6) begin miscompares++; $display("FAIL rmid_fill_count: got %0d expected 6", count); end
      // pop would issue a refill read this cycle; reset must suppress it
      rst = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h99;
      #1;
      vectors++; if (ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL rmid_rd_en: got %0b expected 0", ram_rd_en); end
      vectors++; if (ram_wr_en !== 1'b0) begin miscompares++; $display("FAIL rmid_wr_en: got %0b expected 0", ram_wr_en); end
      step();
      rst = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
      #1;
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_m_valid: got %0b expected 0", m_valid); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL rmid_count: got %0d expected 0", count); end
      vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_s_ready: got %0b expected 1", s_ready); end
      vectors++; if (m_data !== 8'h00) begin miscompares++; $display("FAIL rmid_m_data: got %0h expected 0", m_data); end
      s_valid = 1'b1; s_data = 8'h3C;
      #1;
      vectors++; if (ram_wr_addr !== 2'd0) begin miscompares++; $display("FAIL rmid_wr_addr: got %0d expected 0", ram_wr_addr); end
      step();
      s_valid = 1'b0;
      #1;
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_m_valid_c1: got %0b expected 0", m_valid); end
      step();
      #1;
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_m_valid_c2: got %0b expected 0", m_valid); end
      step();
      #1;
      vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_m_valid_c3: got %0b expected 1", m_valid); end
      vectors++; if (m_data !== 8'h3C) begin miscompares++; $display("FAIL rmid_m_data_c3: got %0h expected 3c", m_data); end
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL rmid_count_c3: got %0d expected 1", count); end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      #1;
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL rmid_final_count: got %0d expected 0", count); end
   endtask

   task automatic test_empty();
      for (int c = 0; c < 20; c++) begin
         s_valid = 1'b0; m_ready = 1'b1;
         #1;
         vectors++; if (ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL empty_rd_en: got %0b expected 0", ram_rd_en); end
         vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL empty_m_valid: got %0b expected 0", m_valid); end
         vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL empty_count: got %0d expected 0", count); end
         step();
      end
      m_ready = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
      test_reset();
      test_single_push();
      test_fill_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_empty();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
